// File: rtl/scc_pkg.sv
// scc_pkg -- constants and helpers shared by the SCC wave reader.
//
// Contents:
//   WAVE_LEN    samples per channel waveform (32)
//   PHASE_W     bits of the per-channel phase (index into the waveform)
//   DEF_CH_NUM  default number of wave channels (5)
//   PERIOD_W    width of a channel period register (12)
//   MIN_PERIOD  smallest period that lets a channel run (9)
//   ch_base()   RAM base address of a channel's waveform
//
// Configuration macro: SCC_CH5_SHARED_EN
//   defined   -> channel 4 shares channel 3's waveform area (base 96)
//   undefined -> every channel has its own 32-word area (160-word layout)
package scc_pkg;

    localparam int WAVE_LEN   = 32;
    localparam int PHASE_W    = $clog2(WAVE_LEN);
    localparam int DEF_CH_NUM = 5;
    localparam int PERIOD_W   = 12;
    localparam int MIN_PERIOD = 9;

    typedef logic [PHASE_W-1:0]  phase_t;
    typedef logic [PERIOD_W-1:0] period_t;

    // Base address of a channel's waveform in the wave RAM.
    function automatic logic [7:0] ch_base(input logic [2:0] ch);
`ifdef SCC_CH5_SHARED_EN
        if (ch == 3'd4) return 8'd96;
`endif
        return 8'(ch) * 8'(WAVE_LEN);
    endfunction

endpackage

// File: rtl/scc_tone_counter.sv
// scc_tone_counter -- period down counter and waveform phase of one channel.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_freq     period value of this channel
//   i_freq_wr  one-cycle strobe: period register was written, reload counter
//   i_tick     last slot cycle of this channel's slot: count one step
//   o_phase    current waveform phase (0..WAVE_LEN-1)
//
// A write reloads the counter and wins over a tick in the same cycle; the
// phase is left alone on a write. Periods below MIN_PERIOD freeze the channel.
module scc_tone_counter
    import scc_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_reset,
    input  period_t i_freq,
    input  logic    i_freq_wr,
    input  logic    i_tick,
    output phase_t  o_phase
);

    period_t r_cnt;
    phase_t  r_phase;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_phase <= '0;
        end else if (i_freq_wr) begin
            r_cnt <= i_freq;
        end else if (i_tick && (i_freq >= PERIOD_W'(MIN_PERIOD))) begin
            if (r_cnt == '0) begin
                r_cnt   <= i_freq;
                r_phase <= r_phase + 1'b1;  // wraps 31 -> 0
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/scc_wave_reader.sv
// scc_wave_reader -- time-multiplexed wave RAM reader for SCC-style channels.
//
// Each channel owns a slot of SLOT_CYCLES clocks. The read for the channel
// is tried in slot cycle 0 and retried in cycles 1 and 2 while cpu_we blocks
// the RAM port; at most one read per slot. The sample is captured one cycle
// after the read and presented with a one-cycle wave_valid strobe in the
// cycle after that. If all three tries are blocked, the channel's previous
// sample is presented in slot cycle 3 instead.
//
// Ports:
//   clk, reset   clock (rising edge), asynchronous active-high reset
//   freq         CH_NUM packed 12-bit periods, channel n at [12n+11:12n]
//   freq_wr      per-channel period-written strobe
//   key_on       per-channel enable (0 -> sample reported as 0)
//   cpu_we       CPU owns the RAM port this cycle
//   sram_a/re/q  wave RAM read address, read strobe, data (one cycle later)
//   wave_q/ch    captured sample and its channel
//   wave_valid   one-cycle strobe when wave_q/wave_ch are updated
//
// Configuration macro: SCC_CH5_SHARED_EN (see scc_pkg::ch_base).
module scc_wave_reader
    import scc_pkg::*;
#(
    parameter int SLOT_CYCLES = 4,
    parameter int CH_NUM      = DEF_CH_NUM
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CH_NUM*PERIOD_W-1:0] freq,
    input  logic [CH_NUM-1:0]          freq_wr,
    input  logic [CH_NUM-1:0]          key_on,
    input  logic                       cpu_we,
    output logic [7:0]                 sram_a,
    output logic                       sram_re,
    input  logic [7:0]                 sram_q,
    output logic [7:0]                 wave_q,
    output logic [2:0]                 wave_ch,
    output logic                       wave_valid
);

    localparam logic [2:0] SLOT_LAST = 3'(SLOT_CYCLES - 1);
    localparam logic [2:0] CH_LAST   = 3'(CH_NUM - 1);

    logic [2:0] r_slot;
    logic [2:0] r_ch;
    logic       r_done;       // read already issued in this slot
    logic       r_pend;       // read issued last cycle, sram_q valid now
    logic [2:0] r_pend_ch;
    logic [7:0] r_last [CH_NUM];

    phase_t     w_phase [CH_NUM];
    logic       w_last_slot;
    logic       w_try;
    logic [7:0] w_sample;

    assign w_last_slot = (r_slot == SLOT_LAST);
    assign w_try       = (r_slot == 3'd0) ||
                         (((r_slot == 3'd1) || (r_slot == 3'd2)) && !r_done);
    // Gated by reset so no read is issued while the block is held in reset.
    assign sram_re     = !reset && !cpu_we && w_try;
    assign sram_a      = ch_base(r_ch) + 8'(w_phase[r_ch]);
    assign w_sample    = key_on[r_pend_ch] ? sram_q : 8'h00;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_tone
        scc_tone_counter u_tone (
            .i_clk     (clk),
            .i_reset   (reset),
            .i_freq    (freq[n*PERIOD_W +: PERIOD_W]),
            .i_freq_wr (freq_wr[n]),
            .i_tick    (w_last_slot && (r_ch == 3'(n))),
            .o_phase   (w_phase[n])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot     <= '0;
            r_ch       <= '0;
            r_done     <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_ch  <= '0;
            wave_q     <= '0;
            wave_ch    <= '0;
            wave_valid <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) r_last[i] <= '0;
        end else begin
            if (w_last_slot) begin
                r_slot <= '0;
                r_ch   <= (r_ch == CH_LAST) ? 3'd0 : r_ch + 3'd1;
            end else begin
                r_slot <= r_slot + 3'd1;
            end

            // Slot cycle 0 starts a fresh slot, so the old flag is dropped.
            r_done    <= (r_slot == 3'd0) ? sram_re : (r_done || sram_re);
            r_pend    <= sram_re;
            r_pend_ch <= r_ch;

            wave_valid <= 1'b0;
            if (r_pend) begin
                wave_q            <= w_sample;
                wave_ch           <= r_pend_ch;
                wave_valid        <= 1'b1;
                r_last[r_pend_ch] <= w_sample;
            end else if ((r_slot == 3'd2) && !r_done && cpu_we) begin
                // Third try blocked as well: repeat the channel's last sample.
                wave_q     <= r_last[r_ch];
                wave_ch    <= r_ch;
                wave_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scc_wave_reader.sv
module tb_scc_wave_reader;

    localparam int LOG_N = 8192;

    typedef enum int {K_VALID, K_CH, K_Q, K_RE, K_A} kind_t;
    typedef struct {
        int    cyc;
        kind_t kind;
        int    exp;
        string name;
    } vec_t;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [59:0] freq    = '0;
    logic [4:0]  freq_wr = '0;
    logic [4:0]  key_on  = '0;
    logic        cpu_we  = 1'b0;
    logic [7:0]  sram_a;
    logic        sram_re;
    logic [7:0]  sram_q  = 8'h00;
    logic [7:0]  wave_q;
    logic [2:0]  wave_ch;
    logic        wave_valid;

    logic [7:0]  mem [256];

    // Per-cycle log of DUT outputs, cycle 0 = first cycle after reset release
    logic        lg_valid [LOG_N];
    logic        lg_re    [LOG_N];
    logic [2:0]  lg_ch    [LOG_N];
    logic [7:0]  lg_q     [LOG_N];
    logic [7:0]  lg_a     [LOG_N];

    // Per-cycle input plans
    logic        we_plan  [LOG_N];
    logic [4:0]  wr_plan  [LOG_N];

    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   base4;
    int   q4;

    scc_wave_reader dut (
        .clk        (clk),
        .reset      (reset),
        .freq       (freq),
        .freq_wr    (freq_wr),
        .key_on     (key_on),
        .cpu_we     (cpu_we),
        .sram_a     (sram_a),
        .sram_re    (sram_re),
        .sram_q     (sram_q),
        .wave_q     (wave_q),
        .wave_ch    (wave_ch),
        .wave_valid (wave_valid)
    );

    // Clock / RAM model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_re) sram_q <= mem[sram_a];
    end

    // Driver / checker tasks
    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input int cyc, input kind_t kind, input int exp, input string name);
        tbl.push_back('{cyc, kind, exp, name});
    endtask

    task automatic clear_plans();
        for (int i = 0; i < LOG_N; i++) begin
            we_plan[i] = 1'b0;
            wr_plan[i] = 5'b0;
        end
        tbl.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sram_re"},    int'(sram_re),    0);
        check({tag, "_sram_a"},     int'(sram_a),     0);
        check({tag, "_wave_valid"}, int'(wave_valid), 0);
        check({tag, "_wave_q"},     int'(wave_q),     0);
        check({tag, "_wave_ch"},    int'(wave_ch),    0);
    endtask

    // Holds reset for two cycles (cpu_we low, so a read would show up),
    // then releases it just after a rising edge: the next cycle is cycle 0.
    task automatic do_reset();
        reset   = 1'b1;
        cpu_we  = 1'b0;
        freq_wr = '0;
        repeat (2) begin
            @(negedge clk);
            check_zero_outputs("rst");
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            cpu_we  = we_plan[c];
            freq_wr = wr_plan[c];
            @(negedge clk);
            lg_valid[c] = wave_valid;
            lg_re[c]    = sram_re;
            lg_ch[c]    = wave_ch;
            lg_q[c]     = wave_q;
            lg_a[c]     = sram_a;
            @(posedge clk);
            #1;
        end
        cpu_we  = 1'b0;
        freq_wr = '0;
    endtask

    task automatic check_table();
        foreach (tbl[i]) begin
            int act;
            case (tbl[i].kind)
                K_VALID: act = int'(lg_valid[tbl[i].cyc]);
                K_CH:    act = int'(lg_ch[tbl[i].cyc]);
                K_Q:     act = int'(lg_q[tbl[i].cyc]);
                K_RE:    act = int'(lg_re[tbl[i].cyc]);
                default: act = int'(lg_a[tbl[i].cyc]);
            endcase
            check($sformatf("%s@%0d", tbl[i].name, tbl[i].cyc), act, tbl[i].exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]   = 8'h7F;
        mem[32]  = 8'h80;
        mem[64]  = 8'h11;
        mem[96]  = 8'h22;
        mem[128] = 8'h33;
`ifdef SCC_CH5_SHARED_EN
        base4 = 96;
        q4    = 8'h22;
`else
        base4 = 128;
        q4    = 8'h33;
`endif

        // Sequence 1: plain scan, all channels on, periods frozen at phase 0
        clear_plans();
        key_on = 5'h1F;
        freq   = '0;
        add(0,  K_RE,    1,     "ch0_re");
        add(0,  K_A,     0,     "ch0_addr");
        add(1,  K_RE,    0,     "one_read_per_slot");
        add(2,  K_VALID, 1,     "ch0_valid");
        add(2,  K_CH,    0,     "ch0_ch");
        add(2,  K_Q,     8'h7F, "ch0_q");
        add(3,  K_VALID, 0,     "strobe_one_cycle");
        add(5,  K_VALID, 0,     "gap_valid");
        add(4,  K_A,     32,    "ch1_addr");
        add(6,  K_VALID, 1,     "ch1_valid");
        add(6,  K_CH,    1,     "ch1_ch");
        add(6,  K_Q,     8'h80, "ch1_q");
        add(10, K_CH,    2,     "ch2_ch");
        add(10, K_Q,     8'h11, "ch2_q");
        add(14, K_CH,    3,     "ch3_ch");
        add(14, K_Q,     8'h22, "ch3_q");
        add(16, K_A,     base4, "ch4_addr");
        add(18, K_VALID, 1,     "ch4_valid");
        add(18, K_CH,    4,     "ch4_ch");
        add(18, K_Q,     q4,    "ch4_q");
        add(22, K_CH,    0,     "wrap_ch");
        add(22, K_Q,     8'h7F, "wrap_q");
        do_reset();
        run(24);
        check_table();

        // Sequence 2: CPU blocking channel 2 (cycles 8..11, 28..31)
        clear_plans();
        key_on = 5'h1F;
        freq   = '0;
        we_plan[8]  = 1'b1;
        we_plan[9]  = 1'b1;
        we_plan[10] = 1'b1;
        we_plan[28] = 1'b1;
        we_plan[29] = 1'b1;
        add(8,  K_RE,    0,     "blk3_re0");
        add(9,  K_RE,    0,     "blk3_re1");
        add(10, K_RE,    0,     "blk3_re2");
        add(11, K_RE,    0,     "blk3_re3");
        add(10, K_VALID, 0,     "blk3_no_early");
        add(11, K_VALID, 1,     "blk3_valid");
        add(11, K_CH,    2,     "blk3_ch");
        add(11, K_Q,     8'h00, "blk3_old_q");
        add(12, K_VALID, 0,     "blk3_single");
        add(28, K_RE,    0,     "blk2_re0");
        add(29, K_RE,    0,     "blk2_re1");
        add(30, K_RE,    1,     "blk2_re2");
        add(30, K_A,     64,    "blk2_addr");
        add(31, K_RE,    0,     "blk2_re3");
        add(30, K_VALID, 0,     "blk2_no_v30");
        add(31, K_VALID, 0,     "blk2_no_v31");
        add(32, K_VALID, 1,     "blk2_valid");
        add(32, K_CH,    2,     "blk2_ch");
        add(32, K_Q,     8'h11, "blk2_q");
        add(32, K_RE,    1,     "ch3_read_after");
        add(34, K_CH,    3,     "ch3_ch_after");
        do_reset();
        run(40);
        check_table();

        // Sequence 3: periods. ch0 = 9 written in its tick cycle (write wins),
        // ch1 = 5 (frozen) and keyed off, ch4 = 9 from reset (reloads on 1st tick)
        clear_plans();
        key_on = 5'b11101;
        freq   = '0;
        freq[0*12 +: 12] = 12'd9;
        freq[1*12 +: 12] = 12'd5;
        freq[4*12 +: 12] = 12'd9;
        wr_plan[3] = 5'b00001;
        for (int p = 0; p <= 32; p++) add(200 * p + 20, K_A, p % 32, "ch0_phase_addr");
        add(200,  K_A,     0,         "ch0_before_step1");
        add(400,  K_A,     1,         "ch0_before_step2");
        add(4,    K_A,     32,        "ch1_frozen_a");
        add(2004, K_A,     32,        "ch1_frozen_b");
        add(6404, K_A,     32,        "ch1_frozen_c");
        add(6,    K_VALID, 1,         "ch1_off_valid");
        add(6,    K_CH,    1,         "ch1_off_ch");
        add(6,    K_Q,     0,         "ch1_off_q");
        add(26,   K_Q,     0,         "ch1_off_q2");
        add(16,   K_A,     base4,     "ch4_ph0");
        add(36,   K_A,     base4 + 1, "ch4_ph1");
        add(416,  K_A,     base4 + 2, "ch4_ph2");
        add(436,  K_A,     base4 + 3, "ch4_ph3");
        do_reset();
        run(6424);
        check_table();

        // Sequence 4: reset pulsed in channel 3, slot cycle 1
        clear_plans();
        key_on = 5'h1F;
        freq   = '0;
        do_reset();
        run(13);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_zero_outputs("mid_rst");
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        add(0, K_VALID, 0,     "post_rst_v0");
        add(1, K_VALID, 0,     "post_rst_v1");
        add(2, K_VALID, 1,     "post_rst_valid");
        add(2, K_CH,    0,     "post_rst_ch");
        add(2, K_Q,     8'h7F, "post_rst_q");
        run(4);
        check_table();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scc_wave_reader.md
SCC_WAVE_READER -- requirements
Module: scc_wave_reader

Interface
REQ-001 SHALL have parameter SLOT_CYCLES, default 4, clocks per channel slot (legal values 4..8).
REQ-002 SHALL have parameter CH_NUM, default 5, number of wave channels.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port freq  input  60  five 12-bit period values; channel n occupies bits [12n+11:12n].
REQ-006 SHALL have port freq_wr  input  5  one-cycle strobe per channel; its period register was written.
REQ-007 SHALL have port key_on  input  5  per-channel enable.
REQ-008 SHALL have port cpu_we  input  1  CPU write to wave RAM in progress this cycle; read port blocked.
REQ-009 SHALL have port sram_a  output  8  wave RAM read address.
REQ-010 SHALL have port sram_re  output  1  read issued this cycle; high only while cpu_we is low.
REQ-011 SHALL have port sram_q  input  8  wave RAM data, valid one cycle after the read is issued.
REQ-012 SHALL have port wave_q  output  8  signed sample of the channel in wave_ch.
REQ-013 SHALL have port wave_ch  output  3  channel index of wave_q.
REQ-014 SHALL have port wave_valid  output  1  one-cycle strobe; wave_q/wave_ch updated.

Function
REQ-015 SHALL run a slot counter 0..SLOT_CYCLES-1 and a channel counter 0..CH_NUM-1, advancing the channel counter when the slot counter wraps to 0.
REQ-016 SHALL hold a 12-bit down counter and a 5-bit phase per channel.
REQ-017 SHALL, in slot cycle 0, drive sram_a = ch*32 + phase and sram_re = 1 unless cpu_we = 1.
REQ-018 SHALL, if the read is blocked, retry in slot cycles 1 and 2; it SHALL issue at most one read per slot.
REQ-019 SHALL capture sram_q exactly one cycle after the read that was issued, and pulse wave_valid in the following cycle.
REQ-020 SHALL, if all three attempts are blocked, pulse wave_valid in slot cycle 3 with the previous wave_q value of that channel.
REQ-021 SHALL output wave_q = 0 when key_on[ch] = 0 at capture time; the phase and counter keep running.
REQ-022 SHALL, in the last slot cycle, decrement the channel's counter; at 0 it reloads freq[ch] and phase increments mod 32 (31 -> 0).
REQ-023 SHALL freeze counter and phase while freq[ch] < 9.
REQ-024 SHALL, on freq_wr[n], reload counter n with freq[n] in the next cycle, leave the phase unchanged, and give it priority over the decrement in the same cycle.
REQ-025 SHALL keep sram_re low whenever cpu_we is high; a CPU write never changes scan timing.

Reset
REQ-026 SHALL, while reset is high, clear the slot counter, channel counter, all counters, all phases, wave_q, wave_ch, wave_valid, sram_re and sram_a to 0.
REQ-027 SHALL, on reset asserted mid-slot, abort any pending capture; the first wave_valid after release is for channel 0.

Configuration
REQ-028 SHALL honour macro SCC_CH5_SHARED_EN. When it is defined, channel 4 reads from channel 3's area (sram_a = 96 + phase), which is classic SCC behaviour. When it is undefined, channel 4 reads 128 + phase, giving a 160-word layout.

Structure
REQ-029 SHALL take from a shared package scc_pkg: the wave length (32), channel count, period width (12), the minimum active period (9) and the channel-base address function.
REQ-030 SHALL use one sub-module, scc_tone_counter, instantiated CH_NUM times, holding the down counter and phase for one channel.

Verification
REQ-031 SHALL verify: reset, key_on = 5'h1F, RAM word 0 = 8'h7F, word 32 = 8'h80 -> first wave_valid has wave_ch = 0 and wave_q = 8'h7F, then wave_ch = 1 and wave_q = 8'h80, spaced SLOT_CYCLES apart.
REQ-032 SHALL verify: freq[0] = 12'd9 -> channel 0 phase advances once every 10 scans (200 clocks at the default parameters), and sram_a steps 0, 1, ... 31, then 0.
REQ-033 SHALL verify: cpu_we held high during slot cycles 0-1 of channel 2 -> read issued in cycle 2 with sram_re = 1, and wave_valid arrives 2 cycles later; cpu_we held high during cycles 0-2 -> wave_valid in cycle 3 with the old sample.
REQ-034 SHALL verify: freq[1] = 12'd5 -> channel 1 phase never changes; key_on[1] = 0 -> channel 1 wave_q = 0.
REQ-035 SHALL verify: phase of channel 4 = 3 -> sram_a = 8'd99 with SCC_CH5_SHARED_EN defined, and 8'd131 without it.
REQ-036 SHALL verify: reset pulsed during channel 3 slot cycle 1 -> all outputs 0 while reset is high, and the first post-reset wave_valid has wave_ch = 0.
